// File: rtl/uart_packet_parser.sv
// Frames UART RX bytes into PREFIX/addr/len/payload/crc packets, buffers the payload and
// replays it downstream over ready/valid once the crc byte has been accepted.
module uart_packet_parser #(
   parameter logic [7:0]  PREFIX      = 8'hDD,
   parameter int unsigned MAX_LEN     = 64,
   parameter int unsigned CRC_EN      = 0,
   parameter int unsigned TIMEOUT_CYC = 200000
) (
   input  logic       clk_100,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [6:0] out_addr,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       busy,
   output logic       err_crc,
   output logic       err_len,
   output logic       err_timeout,
   output logic       err_overrun
);

   localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StLen,
      StPayload,
      StCrc,
      StDrain
   } state_t;

   state_t        state;
   logic [7:0]    mem [MAX_LEN];
   logic [LW-1:0] len;
   logic [LW-1:0] wr_cnt;
   logic [LW-1:0] rd_idx;
   logic [7:0]    acc;
   logic [TW-1:0] tmo_cnt;

   assign busy = (state != StIdle);

   // Payload buffer kept out of the reset domain so it maps onto plain RAM.
   always_ff @(posedge clk_100) begin
      if (state == StPayload && rx_valid) begin
         mem[wr_cnt[IW-1:0]] <= rx_data;
      end
   end

   always_ff @(posedge clk_100) begin
      if (rst) begin
         state       <= StIdle;
         len         <= '0;
         wr_cnt      <= '0;
         rd_idx      <= '0;
         acc         <= '0;
         tmo_cnt     <= '0;
         out_addr    <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         err_crc     <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         err_crc     <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;

         unique case (state)
            StIdle: begin
               if (rx_valid && rx_data == PREFIX) begin
                  acc   <= '0;
                  state <= StAddr;
               end
            end

            StAddr, StLen, StPayload, StCrc: begin
               if (!rx_valid) begin
                  if (tmo_cnt == TMO_LAST) begin
                     err_timeout <= 1'b1;
                     tmo_cnt     <= '0;
                     state       <= StIdle;
                  end else begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end
               end else begin
                  tmo_cnt <= '0;
                  if (state == StAddr) begin
                     if (rx_data[7]) begin
                        err_len <= 1'b1;
                        state   <= StIdle;
                     end else begin
                        out_addr <= rx_data[6:0];
                        acc      <= acc ^ rx_data;
                        state    <= StLen;
                     end
                  end else if (state == StLen) begin
                     if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                        err_len <= 1'b1;
                        state   <= StIdle;
                     end else begin
                        len    <= LW'(rx_data);
                        acc    <= acc ^ rx_data;
                        wr_cnt <= '0;
                        state  <= StPayload;
                     end
                  end else if (state == StPayload) begin
                     acc    <= acc ^ rx_data;
                     wr_cnt <= wr_cnt + 1'b1;
                     if (wr_cnt == len - 1'b1) begin
                        state <= StCrc;
                     end
                  end else begin
                     if (CRC_EN != 0 && rx_data != acc) begin
                        err_crc <= 1'b1;
                        state   <= StIdle;
                     end else begin
                        rd_idx <= '0;
                        state  <= StDrain;
                     end
                  end
               end
            end

            StDrain: begin
               // No backpressure upstream: anything arriving now cannot be stored.
               if (rx_valid) begin
                  err_overrun <= 1'b1;
               end
               if (!out_valid || out_ready) begin
                  if (out_valid && out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= StIdle;
                  end else begin
                     out_valid <= 1'b1;
                     out_data  <= mem[rd_idx[IW-1:0]];
                     out_last  <= (rd_idx == len - 1'b1);
                     rd_idx    <= rd_idx + 1'b1;
                  end
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule
